// File: rtl/obstacle_spawner.sv
// Obstacle spawner: picks when, where and which obstacle falls next, offering it
// to the motion controller over a valid/ready handshake. Randomness from a 16-bit Galois LFSR.
module obstacle_spawner #(
  parameter int          SCREEN_W = 640,
  parameter int          OBST_W   = 32,
  parameter int          MIN_GAP  = 30,
  parameter logic [3:0]  GAP_MASK = 4'hF,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [1:0] obstacle_trigger,
  output logic [9:0] obstacle_start_x,
  output logic [7:0] spawn_count
);

  localparam int          GAP_W = 8;
  localparam logic [9:0]  X_MAX = 10'(SCREEN_W - OBST_W);
  localparam logic [15:0] POLY  = 16'hB400;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_OFFER = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [15:0]        lfsr_r, lfsr_s;
  logic [GAP_W-1:0]   gap_r, gap_s;
  logic               valid_r, valid_s;
  logic [1:0]         trig_r, trig_s;
  logic [9:0]         x_r, x_s;
  logic [7:0]         cnt_r, cnt_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 16'h0000);
  endfunction

  // Fold values past the right edge back onto the screen, then align to 4 px.
  function automatic logic [9:0] offer_x(input logic [9:0] raw);
    logic [9:0] r;
    r = (raw > X_MAX) ? (raw - (X_MAX + 10'd1)) : raw;
    return {r[9:2], 2'b00};
  endfunction

  function automatic logic [1:0] offer_type(input logic [1:0] raw);
    return (raw == 2'b00) ? 2'b01 : raw;
  endfunction

  // Next-state, LFSR and offer-data logic.
  always_comb begin
    state_s = state_r;
    gap_s   = gap_r;
    valid_s = valid_r;
    trig_s  = trig_r;
    x_s     = x_r;
    cnt_s   = cnt_r;
    if (lfsr_r == 16'h0000) begin
      lfsr_s = SEED;
    end else if (enable) begin
      lfsr_s = lfsr_step(lfsr_r);
    end else begin
      lfsr_s = lfsr_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_s = ST_WAIT;
          gap_s   = GAP_W'(MIN_GAP);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (frame_tick) begin
          if (gap_r == {GAP_W{1'b0}}) begin
            state_s = ST_OFFER;
            valid_s = 1'b1;
            trig_s  = offer_type(lfsr_r[11:10]);
            x_s     = offer_x(lfsr_r[9:0]);
          end else begin
            gap_s = gap_r - GAP_W'(1);
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_OFFER: begin
        // An offer stays up until accepted, whatever enable does meanwhile.
        if (spawn_ready) begin
          valid_s = 1'b0;
          trig_s  = 2'b00;
          cnt_s   = (cnt_r == 8'hFF) ? cnt_r : (cnt_r + 8'd1);
          if (enable) begin
            state_s = ST_WAIT;
            gap_s   = GAP_W'(MIN_GAP) + GAP_W'(lfsr_r[15:12] & GAP_MASK);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_OFFER;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        trig_s  = 2'b00;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      lfsr_r  <= SEED;
      gap_r   <= {GAP_W{1'b0}};
      valid_r <= 1'b0;
      trig_r  <= 2'b00;
      x_r     <= 10'd0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      lfsr_r  <= lfsr_s;
      gap_r   <= gap_s;
      valid_r <= valid_s;
      trig_r  <= trig_s;
      x_r     <= x_s;
      cnt_r   <= cnt_s;
    end
  end

  assign spawn_valid      = valid_r;
  assign obstacle_trigger = trig_r;
  assign obstacle_start_x = x_r;
  assign spawn_count      = cnt_r;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: behavioural model compared every cycle,
// directed scenarios for latency, hold, enable drop, async reset and saturation.
module tb_obstacle_spawner;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic       spawn_ready = 1'b0;
  logic       spawn_valid;
  logic [1:0] obstacle_trigger;
  logic [9:0] obstacle_start_x;
  logic [7:0] spawn_count;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  obstacle_spawner dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
    .obstacle_trigger(obstacle_trigger), .obstacle_start_x(obstacle_start_x),
    .spawn_count(spawn_count)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = not running, 1 = counting frames, 2 = offer outstanding.
  int          m_phase = 0;
  int          m_gap = 0;
  logic [15:0] m_lfsr = SEED;
  int          m_x = 0;
  int          m_type = 0;
  int          m_count = 0;
  int          m_accepts = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    if (v == 16'h0000) return SEED;
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int x_of(input int raw);
    int r;
    r = raw;
    if (r > 640 - 32) r = r - (640 - 32 + 1);
    return (r / 4) * 4;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_gap = 0; m_lfsr = SEED; m_x = 0; m_type = 0; m_count = 0;
    end else begin
      if (m_phase == 0) begin
        if (enable) begin m_phase = 1; m_gap = 30; end
      end else if (m_phase == 1) begin
        if (!enable) m_phase = 0;
        else if (frame_tick) begin
          if (m_gap == 0) begin
            m_phase = 2;
            m_x = x_of(int'(m_lfsr[9:0]));
            m_type = (m_lfsr[11:10] == 2'b00) ? 1 : int'(m_lfsr[11:10]);
          end else m_gap = m_gap - 1;
        end
      end else begin
        if (spawn_ready) begin
          m_accepts++;
          if (m_count < 255) m_count++;
          if (enable) begin m_phase = 1; m_gap = 30 + int'(m_lfsr[15:12]); end
          else m_phase = 0;
        end
      end
      m_lfsr = (m_lfsr == 16'h0000) ? SEED : (enable ? lfsr_next(m_lfsr) : m_lfsr);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("spawn_valid", int'(spawn_valid), (m_phase == 2) ? 1 : 0);
      check("obstacle_trigger", int'(obstacle_trigger), (m_phase == 2) ? m_type : 0);
      check("obstacle_start_x", int'(obstacle_start_x), m_x);
      check("spawn_count", int'(spawn_count), m_count);
      if (spawn_valid) begin
        check("trigger_nonzero", (obstacle_trigger != 2'b00) ? 1 : 0, 1);
        check("start_x_range", (obstacle_start_x <= 10'd608 && obstacle_start_x[1:0] == 2'b00) ? 1 : 0, 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_offer();
    frame_tick = 1'b1;
    for (int i = 0; i < 200 && m_phase != 2; i++) step();
    check("offer_reached", (m_phase == 2) ? 1 : 0, 1);
    check("offer_valid_dut", int'(spawn_valid), 1);
  endtask

  initial begin
    // Pin the model against hand-computed values.
    check("model_x_1000", x_of(1000), 388);
    check("model_x_600", x_of(600), 600);
    check("model_x_609", x_of(609), 0);
    check("model_lfsr_step", int'(lfsr_next(SEED)), 16'hE270);

    #11;
    check("rst_valid", int'(spawn_valid), 0);
    check("rst_trigger", int'(obstacle_trigger), 0);
    check("rst_start_x", int'(obstacle_start_x), 0);
    check("rst_count", int'(spawn_count), 0);
    #1 reset = 1'b1;
    checking = 1'b1;

    // Test 1: offer exactly one clock after the 31st frame tick.
    enable = 1'b1; spawn_ready = 1'b1;
    step();
    for (int k = 1; k <= 31; k++) begin
      frame_tick = 1'b1; step();
      check("t1_valid_after_tick", int'(spawn_valid), (k == 31) ? 1 : 0);
      frame_tick = 1'b0;
      if (k < 31) step();
    end
    check("t1_count_before", int'(spawn_count), 0);
    step();
    check("t1_valid_after_accept", int'(spawn_valid), 0);
    check("t1_count_after", int'(spawn_count), 1);

    // Test 3: offer held while ready is low.
    spawn_ready = 1'b0;
    wait_offer();
    for (int i = 0; i < 50; i++) begin
      frame_tick = 1'($urandom_range(0, 1));
      step();
    end
    check("t3_valid_held", int'(spawn_valid), 1);
    spawn_ready = 1'b1; frame_tick = 1'b1;
    step();
    check("t3_valid_drop", int'(spawn_valid), 0);
    spawn_ready = 1'b0;

    // Test 4a: enable drop mid-wait never produces an offer.
    for (int i = 0; i < 5; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 60; i++) step();
    check("t4_no_offer_disabled", int'(spawn_valid), 0);

    // Test 4b: enable drop during an offer keeps it until accepted.
    enable = 1'b1;
    wait_offer();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t4_offer_kept", int'(spawn_valid), 1);
    spawn_ready = 1'b1;
    step();
    check("t4_accept_drop", int'(spawn_valid), 0);
    for (int i = 0; i < 40; i++) step();
    check("t4_idle_after", int'(spawn_valid), 0);

    // Test 5: asynchronous reset during an offer.
    enable = 1'b1; spawn_ready = 1'b0;
    wait_offer();
    #1 reset = 1'b0;
    #1;
    check("t5_valid", int'(spawn_valid), 0);
    check("t5_trigger", int'(obstacle_trigger), 0);
    check("t5_count", int'(spawn_count), 0);
    #4 reset = 1'b1;
    step();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      frame_tick  = 1'($urandom_range(0, 1));
      spawn_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      step();
    end

    // Test 6: saturation over 300 accepts.
    enable = 1'b1; spawn_ready = 1'b1;
    m_accepts = 0;
    for (int i = 0; i < 40000 && m_accepts < 300; i++) begin
      frame_tick = 1'($urandom_range(0, 1));
      step();
    end
    check("t6_accepts_done", (m_accepts >= 300) ? 1 : 0, 1);
    check("t6_count_saturated", int'(spawn_count), 255);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
